// File: rtl/fft32_pkg.sv
// Shared constants and types for the FFT32 frame source.
// Frame geometry, FSM encoding and RAM address packing.
package fft32_pkg;

  localparam int FRAME_LEN = 32;
  localparam int IDX_W     = 5;
  localparam int ADDR_W    = IDX_W + 1;
  localparam int CNT_W     = 16;
  localparam int GAP_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STRT,
    ST_STREAM,
    ST_GAP
  } fsm_t;

  function automatic logic [ADDR_W-1:0] ram_addr(
    input logic             bank,
    input logic [IDX_W-1:0] idx
  );
    return {bank, idx};
  endfunction

endpackage

// File: rtl/fft32_bank_ram.sv
// Ping-pong sample store: 2 banks x 32 words, one write, one read port.
// Read data is registered and reads back zero when no read is issued.
module fft32_bank_ram
  import fft32_pkg::*;
#(
  parameter int W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [W-1:0]      i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [W-1:0]      o_rdata
);

  logic [W-1:0] r_mem [0:2*FRAME_LEN-1];
  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // The read register doubles as the output register, so it clears
  // whenever no sample is being fetched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_re) begin
      r_q <= r_mem[i_raddr];
    end else begin
      r_q <= '0;
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/fft32_frame_source.sv
// Collects upstream samples into 32-sample frames and replays each
// frame to FFT32 as a START pulse followed by 32 serial samples.
module fft32_frame_source
  import fft32_pkg::*;
#(
  parameter int nb        = 16,
  parameter int FRAME_GAP = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             S_VALID,
  output logic             S_READY,
  input  logic [nb-1:0]    S_DR,
  input  logic [nb-1:0]    S_DI,
  input  logic             S_LAST,
  output logic             START,
  output logic [nb-1:0]    DR,
  output logic [nb-1:0]    DI,
  output logic             BUSY,
  output logic             FRAME_ERR,
  output logic [CNT_W-1:0] FRAME_CNT
);

  localparam int GAP_LAST_I =
    (FRAME_GAP > 0) ? FRAME_GAP - 1 : 0;
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'(GAP_LAST_I);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(FRAME_LEN - 1);

  fsm_t             r_state;
  fsm_t             w_nstate;
  logic             r_live;
  logic [1:0]       r_full;
  logic [1:0]       w_full_nxt;
  logic             r_wb;
  logic             r_rb;
  logic [IDX_W-1:0] r_widx;
  logic [IDX_W-1:0] r_ridx;
  logic [GAP_W-1:0] r_gap;
  logic             r_start;
  logic             r_busy;
  logic             r_ferr;
  logic [CNT_W-1:0] r_cnt;

  logic              w_hs;
  logic              w_widx_last;
  logic              w_ok;
  logic              w_bad;
  logic              w_ridx_last;
  logic              w_end;
  logic              w_re;
  logic [IDX_W-1:0]  w_ridx_rd;
  logic [ADDR_W-1:0] w_waddr;
  logic [ADDR_W-1:0] w_raddr;
  logic [2*nb-1:0]   w_wdata;
  logic [2*nb-1:0]   w_rdata;

  // r_live keeps S_READY low while reset is held.
  assign S_READY     = r_live & ~r_full[r_wb];
  assign w_hs        = S_VALID & S_READY;
  assign w_widx_last = (r_widx == IDX_LAST);
  assign w_ok        = w_hs & S_LAST & w_widx_last;
  assign w_bad       = w_hs & (S_LAST ^ w_widx_last);

  assign w_ridx_last = (r_ridx == IDX_LAST);
  assign w_end       = (r_state == ST_STREAM)
                     & w_ridx_last;

  // Fetch one ahead: STRT fetches sample 0, STREAM at ridx
  // fetches ridx+1, and nothing is fetched on sample 31.
  assign w_re =
    (r_state == ST_STRT)
    | ((r_state == ST_STREAM) & ~w_ridx_last);
  assign w_ridx_rd =
    (r_state == ST_STRT) ? '0
                         : r_ridx + IDX_W'(1);

  assign w_waddr = ram_addr(r_wb, r_widx);
  assign w_raddr = ram_addr(r_rb, w_ridx_rd);
  assign w_wdata = {S_DR, S_DI};

  fft32_bank_ram #(
    .W (2*nb)
  ) u_ram (
    .clk     (CLK),
    .rst_n   (RST),
    .i_we    (w_hs),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign DR = w_rdata[2*nb-1:nb];
  assign DI = w_rdata[nb-1:0];

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (r_full[r_rb]) begin
          w_nstate = ST_STRT;
        end
      end
      ST_STRT: begin
        w_nstate = ST_STREAM;
      end
      ST_STREAM: begin
        if (w_end) begin
          if (FRAME_GAP > 0) begin
            w_nstate = ST_GAP;
          end else if (r_full[~r_rb]) begin
            w_nstate = ST_STRT;
          end else begin
            w_nstate = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (r_gap == GAP_LAST) begin
          w_nstate = r_full[r_rb] ? ST_STRT
                                  : ST_IDLE;
        end
      end
      default: begin
        w_nstate = ST_IDLE;
      end
    endcase
  end

  // Set and clear never target the same bank: a bank being
  // replayed is full, so it cannot be the write bank.
  always_comb begin
    w_full_nxt = r_full;
    if (w_end) begin
      w_full_nxt[r_rb] = 1'b0;
    end
    if (w_ok) begin
      w_full_nxt[r_wb] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
      r_live  <= 1'b0;
      r_full  <= '0;
      r_wb    <= 1'b0;
      r_rb    <= 1'b0;
      r_widx  <= '0;
      r_ridx  <= '0;
      r_gap   <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_ferr  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nstate;
      r_live  <= 1'b1;
      r_full  <= w_full_nxt;
      r_ferr  <= w_bad;
      r_start <= (w_nstate == ST_STRT);
      r_busy  <= (w_nstate == ST_STRT)
               | (w_nstate == ST_STREAM);

      if (w_ok) begin
        r_wb <= ~r_wb;
      end

      if (w_ok | w_bad) begin
        r_widx <= '0;
      end else if (w_hs) begin
        r_widx <= r_widx + IDX_W'(1);
      end

      if (r_state == ST_STREAM) begin
        r_ridx <= r_ridx + IDX_W'(1);
      end else begin
        r_ridx <= '0;
      end

      if (r_state == ST_GAP) begin
        r_gap <= r_gap + GAP_W'(1);
      end else begin
        r_gap <= '0;
      end

      if (w_end) begin
        r_rb  <= ~r_rb;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign START     = r_start;
  assign BUSY      = r_busy;
  assign FRAME_ERR = r_ferr;
  assign FRAME_CNT = r_cnt;

endmodule
